seq_fsm_scheduler: RTL
======================

Name: seq_fsm_scheduler

Overview:
- Shares one serial Mealy sequence-detector FSM among NREQ requesters.
- Each requester submits a parallel WORD_W-bit word. The scheduler arbitrates round-robin, resets the FSM to its start state, and shifts the word into the FSM's serial input LSB-first.
- It captures the FSM's serial output bit-for-bit into a result word and returns the result with the winning requester's ID.
- Sits between requester logic and the detector FSM; the FSM needs no clock gating or reset hacks of its own.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WORD_W, 8, bits per transaction (2..32).
- IDW, 1, requester-ID width; must be at least ceil(log2(NREQ)).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- req, input, NREQ: per-requester request; held high until the matching gnt.
- req_data, input, NREQ*WORD_W: requester i's word is in bits [i*WORD_W +: WORD_W].
- gnt, output, NREQ: one-hot, 1-cycle grant pulse; data is latched in this cycle.
- busy, output, 1: high from the grant cycle until the cycle after done.
- fsm_rst, output, 1: synchronous reset to the FSM.
- fsm_x, output, 1: serial data to the FSM input.
- fsm_y, input, 1: FSM output; Mealy, so combinational on fsm_x and state.
- done, output, 1: 1-cycle pulse; result and done_id are valid.
- done_id, output, IDW: index of the served requester.
- result, output, WORD_W: captured FSM output bits; bit k corresponds to input bit k.

Behaviour:
- Reset values (reset high, asynchronous):
  - All outputs 0 except fsm_rst = 1.
  - State = IDLE.
  - Round-robin pointer = NREQ-1, so requester 0 has highest priority first.
  - result = 0, done_id = 0, internal bit counter = 0.
- State machine: IDLE, FRST, SHIFT, DONE.
- IDLE:
  - fsm_rst = 0, fsm_x = 0.
  - If any req bit is set, pick the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - In the same cycle: pulse gnt[w], latch req_data word w and ID w, set pointer = w, go to FRST.
  - If no req, stay in IDLE.
- FRST: fsm_rst = 1 for exactly one cycle; clear the bit counter; go to SHIFT.
- SHIFT:
  - Runs exactly WORD_W cycles, k = 0..WORD_W-1.
  - fsm_x = latched_word[k].
  - At each rising edge, result[k] takes fsm_y as sampled in that cycle.
  - After k = WORD_W-1, go to DONE.
- DONE:
  - done = 1, done_id = latched ID.
  - result holds its value until the next grant's FRST cycle clears it.
  - Go to IDLE.
- busy is combinational: high whenever state is not IDLE, and also high in the grant cycle.
- Latency, with grant at cycle 0: FRST at cycle 1, SHIFT at cycles 2..WORD_W+1, done at cycle WORD_W+2. Earliest next grant is cycle WORD_W+3.
- Requests arriving while not in IDLE are ignored until IDLE; they are not queued beyond the req level.
- req dropped before gnt is treated as withdrawn; it is never granted.
- All requesters asserting together: strict rotation, so each requester is served once per NREQ transactions.
- Reset asserted mid-transaction: abort immediately.
  - No done is issued; the partial result is discarded (result = 0).
  - fsm_rst is held high for as long as reset is asserted.
  - The first grant after reset release goes to the lowest-index requester.
- req_data changes after the gnt cycle have no effect on the transaction.

Optional Feature:
- Macro: SEQ_FSM_SCHED_HITCNT_EN.
- Defined:
  - Adds output hit_cnt, width ceil(log2(WORD_W+1)).
  - Counts fsm_y == 1 samples during SHIFT; cleared in FRST.
  - Valid with done and held until the next FRST.
  - Reset value 0.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Loopback, fsm_y = fsm_x; req = 2'b01, req_data[7:0] = 8'hA5 -> gnt = 01 at c0, fsm_rst at c1, fsm_x = 1,0,1,0,0,1,0,1 over c2..c9, done at c10, result = 8'hA5, done_id = 0.
- Both requesters hold req = 2'b11; word 0 = 8'h0F, word 1 = 8'hF0; loopback -> grants in order 0, 1, 0; results 8'h0F, 8'hF0, 8'h0F; gnt spacing 11 cycles.
- fsm_y tied 0; any word -> result = 8'h00, done after 11 cycles. With HITCNT_EN: loopback on 8'hA5 gives hit_cnt = 4.
- Reset pulsed at cycle 5 of a transaction -> no done; busy = 0, fsm_rst = 1 during reset, result = 0; the next req = 2'b10 is granted normally.
- req = 2'b10 dropped after 1 cycle while busy serving requester 0 -> requester 1 is never granted; busy falls after done.
- req_data changed in the cycle after gnt -> result reflects the original latched word.

Source files
------------

// File: rtl/seq_fsm_scheduler.sv
// Round-robin scheduler that time-shares one serial Mealy detector FSM among NREQ requesters.
// Optional hit counter output enabled by defining SEQ_FSM_SCHED_HITCNT_EN.
module seq_fsm_scheduler #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 8,
  parameter int IDW    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     fsm_rst,
  output logic                     fsm_x,
  input  logic                     fsm_y,
  output logic                     done,
  output logic [IDW-1:0]           done_id,
  output logic [WORD_W-1:0]        result
`ifdef SEQ_FSM_SCHED_HITCNT_EN
  ,
  output logic [$clog2(WORD_W+1)-1:0] hit_cnt
`endif
);

  localparam int CW = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, FRST, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    ptr, id_q, win;
  logic              win_vld;
  logic              take;
  logic [WORD_W-1:0] word_q;
  logic [CW-1:0]     cnt;
  logic              last_bit;

  // First requester above the pointer wins; scanning downward lets the lowest offset overwrite.
  always_comb begin : arbiter
    int idx;
    idx     = 0;
    win     = ptr;
    win_vld = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        win     = IDW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  assign take     = (state == IDLE) && win_vld;
  assign last_bit = (cnt == CW'(WORD_W - 1));

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    busy      = 1'b1;
    fsm_rst   = 1'b0;
    fsm_x     = 1'b0;
    done      = 1'b0;
    done_id   = '0;
    unique case (state)
      IDLE: begin
        busy = take;
        if (take) begin
          gnt[win]  = 1'b1;
          state_nxt = FRST;
        end
      end
      FRST: begin
        fsm_rst   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        fsm_x = word_q[cnt];
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        done_id   = id_q;
        state_nxt = IDLE;
      end
    endcase
    // Reset holds the detector in reset and masks the request-driven combinational outputs.
    if (reset) begin
      gnt     = '0;
      busy    = 1'b0;
      fsm_rst = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= IDW'(NREQ - 1);
      id_q   <= '0;
      word_q <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        ptr    <= win;
        id_q   <= win;
        word_q <= req_data[int'(win)*WORD_W +: WORD_W];
      end
      if (state == FRST) begin
        cnt    <= '0;
        result <= '0;
      end else if (state == SHIFT) begin
        result[cnt] <= fsm_y;
        cnt         <= cnt + CW'(1);
      end
    end
  end

`ifdef SEQ_FSM_SCHED_HITCNT_EN
  localparam int HW = $clog2(WORD_W + 1);
  logic [HW-1:0] hit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= '0;
    end else if (state == FRST) begin
      hit_q <= '0;
    end else if (state == SHIFT && fsm_y) begin
      hit_q <= hit_q + HW'(1);
    end
  end

  assign hit_cnt = hit_q;
`endif

endmodule
